// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - registered PIC16C5x-style ALU behind a valid/ready handshake
// Define ALU_PIPE_MUL_EN to build the iterative shift-add MULWF path.
module alu_pipe #(
  parameter int DATA_WIDTH    = 8,
  parameter int BIT_SEL_WIDTH = $clog2(DATA_WIDTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     inValid,
  output logic                     inReady,
  input  logic [DATA_WIDTH-1:0]    wIn,
  input  logic [DATA_WIDTH-1:0]    fIn,
  input  logic [DATA_WIDTH-1:0]    lIn,
  input  logic [4:0]               funcIn,
  input  logic [BIT_SEL_WIDTH-1:0] bitSel,
  input  logic                     cFlag,
  output logic                     outValid,
  input  logic                     outReady,
  output logic [DATA_WIDTH-1:0]    aluResultOut,
  output logic [DATA_WIDTH-1:0]    aluResultHiOut,
  output logic [2:0]               aluStatusOut,
  output logic                     busy
);

  localparam int H = DATA_WIDTH / 2;

  localparam logic [4:0] F_ADDWF = 5'd1,  F_SUBWF = 5'd2,  F_ANDWF = 5'd3,  F_COMF  = 5'd4;
  localparam logic [4:0] F_DECF  = 5'd5,  F_INCF  = 5'd6,  F_IORWF = 5'd7,  F_RLF   = 5'd8;
  localparam logic [4:0] F_RRF   = 5'd9,  F_SWAPF = 5'd10, F_XORWF = 5'd11, F_BCF   = 5'd12;
  localparam logic [4:0] F_BSF   = 5'd13, F_ANDLW = 5'd14, F_IORLW = 5'd15;

  typedef enum logic {IDLE, MUL} state_t;
  state_t state, stateNext;

  logic                      accept, outFree, mulStart, mulDone, loadSingle;
  logic [2*DATA_WIDTH-1:0]   product;
  logic [DATA_WIDTH:0]       addSum;
  logic [DATA_WIDTH-1:0]     opResult;
  logic                      opC, opDc;

  assign outFree    = !outValid || outReady;
  assign inReady    = (state == IDLE) && outFree;
  assign accept     = inValid && inReady;
  assign loadSingle = accept && !mulStart;
  assign addSum     = {1'b0, fIn} + {1'b0, wIn};

`ifdef ALU_PIPE_MUL_EN
  localparam logic [4:0] F_MULWF = 5'd16;

  logic [DATA_WIDTH-1:0]    mcand, acc, mq;
  logic [BIT_SEL_WIDTH-1:0] stepCnt;
  logic [DATA_WIDTH:0]      stepSum;
  logic                     lastStep;

  // {acc, mq} shifts right one bit per step; after DATA_WIDTH steps it holds f * w.
  assign stepSum  = {1'b0, acc} + (mq[0] ? {1'b0, mcand} : '0);
  assign lastStep = (stepCnt == BIT_SEL_WIDTH'(DATA_WIDTH - 1));
  assign mulStart = accept && (funcIn == F_MULWF);
  assign mulDone  = (state == MUL) && lastStep && outFree;
  assign product  = {stepSum[DATA_WIDTH:1], stepSum[0], mq[DATA_WIDTH-1:1]};
  assign busy     = (state == MUL);

  // The final step is folded into the result load so a stalled finish never over-shifts.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand   <= '0;
      acc     <= '0;
      mq      <= '0;
      stepCnt <= '0;
    end else if (mulStart) begin
      mcand   <= fIn;
      acc     <= '0;
      mq      <= wIn;
      stepCnt <= '0;
    end else if ((state == MUL) && !lastStep) begin
      acc     <= stepSum[DATA_WIDTH:1];
      mq      <= {stepSum[0], mq[DATA_WIDTH-1:1]};
      stepCnt <= stepCnt + BIT_SEL_WIDTH'(1);
    end
  end
`else
  assign mulStart = 1'b0;
  assign mulDone  = 1'b0;
  assign product  = '0;
  assign busy     = 1'b0;
`endif

  always_comb begin
    opResult = '0;
    opC      = 1'b0;
    opDc     = 1'b0;
    case (funcIn)
      F_ADDWF: begin
        opResult = addSum[DATA_WIDTH-1:0];
        opC      = addSum[DATA_WIDTH];
        opDc     = addSum[H] ^ fIn[H] ^ wIn[H];
      end
      F_SUBWF: begin
        opResult = fIn - wIn;
        opC      = (fIn >= wIn);
        opDc     = (fIn[H-1:0] >= wIn[H-1:0]);
      end
      F_ANDWF: opResult = fIn & wIn;
      F_COMF:  opResult = ~fIn;
      F_DECF:  opResult = fIn - DATA_WIDTH'(1);
      F_INCF:  opResult = fIn + DATA_WIDTH'(1);
      F_IORWF: opResult = fIn | wIn;
      F_RLF: begin
        opResult = {fIn[DATA_WIDTH-2:0], cFlag};
        opC      = fIn[DATA_WIDTH-1];
      end
      F_RRF: begin
        opResult = {cFlag, fIn[DATA_WIDTH-1:1]};
        opC      = fIn[0];
      end
      F_SWAPF: opResult = {fIn[H-1:0], fIn[DATA_WIDTH-1:H]};
      F_XORWF: opResult = fIn ^ wIn;
      F_BCF: begin
        opResult         = fIn;
        opResult[bitSel] = 1'b0;
      end
      F_BSF: begin
        opResult         = fIn;
        opResult[bitSel] = 1'b1;
      end
      F_ANDLW: opResult = wIn & lIn;
      F_IORLW: opResult = wIn | lIn;
      default: opResult = '0;
    endcase
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (mulStart) stateNext = MUL;
      MUL:     if (mulDone) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outValid       <= 1'b0;
      aluResultOut   <= '0;
      aluResultHiOut <= '0;
      aluStatusOut   <= '0;
    end else if (loadSingle) begin
      outValid       <= 1'b1;
      aluResultOut   <= opResult;
      aluResultHiOut <= '0;
      aluStatusOut   <= {(opResult == '0), opDc, opC};
    end else if (mulDone) begin
      outValid       <= 1'b1;
      aluResultOut   <= product[DATA_WIDTH-1:0];
      aluResultHiOut <= product[2*DATA_WIDTH-1:DATA_WIDTH];
      aluStatusOut   <= {(product == '0), 1'b0, (product[2*DATA_WIDTH-1:DATA_WIDTH] != '0)};
    end else if (outReady) begin
      outValid       <= 1'b0;
    end
  end

endmodule
